serial_subtractor: RTL and testbench

Bit-serial subtractor that computes a - b - bin, one bit per clock, LSB first, using a single full-subtractor cell. It is the sequential subtract counterpart to the team's combinational ripple-carry adders. It trades latency for area in the datapath library and uses a start/busy/done handshake so a controller can sequence operations.

---
 rtl/serial_subtractor_if.sv | 17 +
 rtl/serial_subtractor.sv | 66 ++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (output start, a, b, bin, input diff, bout, zero, busy, done);
    modport slave  (input start, a, b, bin, output diff, bout, zero, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] sa, sb, res, res_n;
    logic [CW-1:0]    cnt;
    logic             br, br_n, d, last, load;

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;

    // full-subtractor cell on the current LSBs, and next-state selection
    always_comb begin
        d     = sa[0] ^ sb[0] ^ br;
        br_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_n = WIDTH'({d, res} >> 1);
        last  = cnt == CW'(WIDTH - 1);
        load  = bus.start && state != RUN;
        nxt   = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // operand shifters, borrow flop, bit counter and published result
    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.zero <= 1'b0;
        end else if (load) begin
            sa  <= bus.a;
            sb  <= bus.b;
            br  <= bus.bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_n;
            res <= res_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                bus.diff <= res_n;
                bus.bout <= br_n;
                bus.zero <= res_n == '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp = 0;
    int   err = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [31:0] TIM_OK = {8'(W), 8'd1, 8'(W + 1), 6'd0, 1'b1, 1'b0};

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic mbin);
        int          full;
        logic [31:0] u;
        logic [W-1:0] md;
        full = int'(ma) - int'(mb) - int'(mbin);
        u    = full;
        md   = u[W-1:0];
        return {md, full < 0, md == '0};
    endfunction

    task automatic exec(input logic [W-1:0] ia, ib, input logic ibin, input int inject,
                        output logic [W+1:0] res, output logic [31:0] tim);
        logic [W-1:0] prev;
        int   nbusy = 0, ndone = 0, lat = 0;
        logic held = 1'b1, both = 1'b0;
        res = '0;
        @(negedge clk);
        prev = bus.diff;
        bus.start = 1'b1;
        bus.a = ia;
        bus.b = ib;
        bus.bin = ibin;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    res = {bus.diff, bus.bout, bus.zero};
                end
            end
            if (bus.busy && bus.done) both = 1'b1;
            if (c <= W && bus.diff !== prev) held = 1'b0;
            bus.start = (c == inject);
            bus.a     = (c == inject) ? W'(1) : W'($urandom);
            bus.b     = (c == inject) ? W'(2) : W'($urandom);
            bus.bin   = 1'($urandom);
        end
        bus.start = 1'b0;
        tim = {8'(nbusy), 8'(ndone), 8'(lat), 6'd0, held, both};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp++;
        if ({bus.diff, bus.bout, bus.zero, bus.busy, bus.done} !== '0) begin
            err++;
            $display("FAIL reset: got %b expected 0", {bus.diff, bus.bout, bus.zero, bus.busy, bus.done});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{4'd9, 4'd3, 4'd0, 4'd5, 4'd5};
        logic [W-1:0] tb [5] = '{4'd3, 4'd9, 4'd0, 4'd5, 4'd4};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W+1:0] te [5] = '{{4'd6, 2'b00}, {4'd10, 2'b10}, {4'd15, 2'b10}, {4'd0, 2'b01}, {4'd0, 2'b01}};
        logic [W+1:0] res;
        logic [31:0]  tim;
        for (int i = 0; i < 5; i++) begin
            exec(ta[i], tb[i], tc[i], 0, res, tim);
            cmp++;
            if (res !== te[i]) begin
                err++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, res, te[i]);
            end
            cmp++;
            if (tim !== TIM_OK) begin
                err++;
                $display("FAIL directed_timing[%0d]: got %h expected %h", i, tim, TIM_OK);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W+1:0] res;
        logic [31:0]  tim;
        exec(4'd9, 4'd3, 1'b0, 2, res, tim);
        cmp++;
        if (res !== {4'd6, 2'b00}) begin
            err++;
            $display("FAIL ignore_start_result: got %h expected %h", res, {4'd6, 2'b00});
        end
        cmp++;
        if (tim !== TIM_OK) begin
            err++;
            $display("FAIL ignore_start_timing: got %h expected %h", tim, TIM_OK);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ka [3] = '{4'd9, 4'd7, 4'd12};
        logic [W-1:0] kb [3] = '{4'd3, 4'd1, 4'd5};
        logic [W-1:0] ke [3] = '{4'd6, 4'd6, 4'd7};
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.start = 1'b1;
            bus.a = ka[k];
            bus.b = kb[k];
            bus.bin = 1'b0;
            @(negedge clk);
            bus.start = 1'b0;
            cmp++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                err++;
                $display("FAIL b2b_busy[%0d]: got %b expected 10", k, {bus.busy, bus.done});
            end
            repeat (W) @(negedge clk);
            cmp++;
            if ({bus.done, bus.busy, bus.diff} !== {2'b10, ke[k]}) begin
                err++;
                $display("FAIL b2b_done[%0d]: got %h expected %h", k, {bus.done, bus.busy, bus.diff}, {2'b10, ke[k]});
            end
        end
        @(negedge clk);
        cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            err++;
            $display("FAIL b2b_idle: got %b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W+1:0] res, exp_res;
        logic [31:0]  tim;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            exp_res = model(ra, rb, rc);
            exec(ra, rb, rc, 0, res, tim);
            cmp++;
            if (res !== exp_res) begin
                err++;
                $display("FAIL random_result[%0d] %h-%h-%b: got %h expected %h", i, ra, rb, rc, res, exp_res);
            end
            cmp++;
            if (tim !== TIM_OK) begin
                err++;
                $display("FAIL random_timing[%0d]: got %h expected %h", i, tim, TIM_OK);
            end
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 4'd9;
        bus.b = 4'd3;
        bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp++;
        if ({bus.diff, bus.bout, bus.zero, bus.busy, bus.done} !== '0) begin
            err++;
            $display("FAIL reset_abort_state: got %b expected 0", {bus.diff, bus.bout, bus.zero, bus.busy, bus.done});
        end
        rst = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        cmp++;
        if (ndone !== 0) begin
            err++;
            $display("FAIL reset_abort_activity: got %0d expected 0", ndone);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
